// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: shared constants and state encoding for the ADC capture
// controller and its address-wrap helper.
//   DEPTH    - sample buffer depth (addresses 0..DEPTH-1)
//   AW, DW   - buffer address / sample widths
//   MIDSCALE - offset-binary zero level of the ADC
package adc_capture_pkg;
  localparam int DEPTH    = 5120;
  localparam int AW       = 13;
  localparam int DW       = 10;
  localparam int MIDSCALE = 512;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;
endpackage

// File: rtl/adc_capture_ctrl_if.sv
// adc_capture_ctrl_if: single-port sample buffer bus.
//   ram_ce/ram_wre  - access strobe / write enable
//   ram_oce         - output clock enable (tied high by the controller)
//   ram_ad          - physical address
//   ram_din         - write data
//   ram_dout        - read data, valid the cycle after a read strobe
// master = capture controller, slave = buffer RAM.
interface adc_capture_ctrl_if;
  import adc_capture_pkg::*;
  logic          ram_ce;
  logic          ram_oce;
  logic          ram_wre;
  logic [AW-1:0] ram_ad;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  modport master (output ram_ce, ram_oce, ram_wre, ram_ad, ram_din, input ram_dout);
  modport slave  (input ram_ce, ram_oce, ram_wre, ram_ad, ram_din, output ram_dout);
endinterface

// File: rtl/adc_addr_wrap.sv
// adc_addr_wrap: combinational modular address arithmetic over the buffer.
//   i_a, i_b - operands, both < DEPTH
//   i_sub    - 0: (a + b) mod DEPTH, 1: (a - b) mod DEPTH
//   o_y      - result
// Uses a single conditional correction instead of a divider.
module adc_addr_wrap
  import adc_capture_pkg::*;
(
  input  logic [AW-1:0] i_a,
  input  logic [AW-1:0] i_b,
  input  logic          i_sub,
  output logic [AW-1:0] o_y
);
  localparam logic [AW:0]   DEPTH_X = DEPTH[AW:0];
  localparam logic [AW-1:0] DEPTH_A = DEPTH[AW-1:0];

  logic [AW:0]   w_sum;
  logic [AW-1:0] w_dif;

  always_comb begin
    w_sum = {1'b0, i_a} + {1'b0, i_b};
    if (w_sum >= DEPTH_X) w_sum = w_sum - DEPTH_X;
    // a - b wraps mod 2^AW; adding DEPTH on borrow lands back in 0..DEPTH-1
    w_dif = i_a - i_b;
    if (i_a < i_b) w_dif = w_dif + DEPTH_A;
    o_y = i_sub ? w_dif : w_sum[AW-1:0];
  end
endmodule

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: circular pre-trigger capture into the sample buffer,
// amplitude trigger, fixed-length post-trigger fill, then frozen readout by
// logical index (0 = oldest pre-trigger sample, PRE = trigger sample).
//   clk, reset          - clock, synchronous active-high reset
//   i_arm               - start (or restart from DONE) a capture
//   i_adc_valid/_data   - sample stream
//   i_threshold         - trigger level on |sample - midscale|
//   o_busy              - ARMED or CAPTURE
//   o_capture_done      - DONE, buffer frozen
//   i_rd_en/i_rd_addr   - logical read request (DONE only)
//   o_rd_valid/_data    - read result, 2 cycles after request
//   ram                 - buffer bus (master)
module adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int PRE = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_arm,
  input  logic                  i_adc_valid,
  input  logic [DW-1:0]         i_adc_data,
  input  logic [8:0]            i_threshold,
  output logic                  o_busy,
  output logic                  o_capture_done,
  input  logic                  i_rd_en,
  input  logic [AW-1:0]         i_rd_addr,
  output logic                  o_rd_valid,
  output logic [DW-1:0]         o_rd_data,
  adc_capture_ctrl_if.master    ram
);
  localparam int            REM_I   = DEPTH - PRE - 1;
  localparam logic [AW-1:0] DEPTH_A = DEPTH[AW-1:0];
  localparam logic [AW-1:0] PRE_A   = PRE[AW-1:0];
  localparam logic [AW-1:0] REM_A   = REM_I[AW-1:0];
  localparam logic [AW-1:0] ONE_A   = {{(AW-1){1'b0}}, 1'b1};

  state_e        r_state;
  logic [AW-1:0] r_wptr, r_fill, r_rem, r_start;
  logic          r_busy, r_done;
  logic [1:0]    r_rd_vld;   // [0]: read strobe on the bus, [1]: data on ram_dout
  logic [DW-1:0] r_rd_hold;

  logic [AW-1:0] w_wptr_nxt, w_start, w_rd_phys;
  logic [DW:0]   w_diff, w_mag;
  logic          w_trig;

  adc_addr_wrap u_inc   (.i_a(r_wptr),  .i_b(ONE_A),     .i_sub(1'b0), .o_y(w_wptr_nxt));
  adc_addr_wrap u_start (.i_a(r_wptr),  .i_b(PRE_A),     .i_sub(1'b1), .o_y(w_start));
  adc_addr_wrap u_rdmap (.i_a(r_start), .i_b(i_rd_addr), .i_sub(1'b0), .o_y(w_rd_phys));

  // 11-bit signed distance from midscale; |-512| = 512 still fits unsigned
  assign w_diff = {1'b0, i_adc_data} - MIDSCALE[DW:0];
  assign w_mag  = w_diff[DW] ? -w_diff : w_diff;
  assign w_trig = (r_fill == PRE_A) && (w_mag > {{(DW-8){1'b0}}, i_threshold});

  assign ram.ram_oce    = 1'b1;
  assign o_busy         = r_busy;
  assign o_capture_done = r_done;
  assign o_rd_valid     = r_rd_vld[1];
  // ram_dout is live during the valid cycle; afterwards the captured copy holds
  assign o_rd_data      = r_rd_vld[1] ? ram.ram_dout : r_rd_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_wptr      <= '0;
      r_fill      <= '0;
      r_rem       <= '0;
      r_start     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_vld    <= '0;
      r_rd_hold   <= '0;
      ram.ram_ce  <= 1'b0;
      ram.ram_wre <= 1'b0;
      ram.ram_ad  <= '0;
      ram.ram_din <= '0;
    end else begin
      ram.ram_ce  <= 1'b0;
      ram.ram_wre <= 1'b0;
      r_rd_vld    <= {r_rd_vld[0], 1'b0};
      if (r_rd_vld[1]) r_rd_hold <= ram.ram_dout;

      case (r_state)
        ST_IDLE: begin
          if (i_arm) begin
            r_state <= ST_ARMED;
            r_wptr  <= '0;
            r_fill  <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (i_adc_valid) begin
            ram.ram_ce  <= 1'b1;
            ram.ram_wre <= 1'b1;
            ram.ram_ad  <= r_wptr;
            ram.ram_din <= i_adc_data;
            r_wptr      <= w_wptr_nxt;
            if (r_fill != PRE_A) r_fill <= r_fill + ONE_A;
            if (w_trig) begin
              r_start <= w_start;
              r_rem   <= REM_A;
              if (REM_I == 0) begin
                r_state <= ST_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state <= ST_CAPTURE;
              end
            end
          end
        end
        ST_CAPTURE: begin
          // r_rem = post-trigger samples still owed; the write that consumes
          // the last one completes the DEPTH-sample window
          if (i_adc_valid) begin
            ram.ram_ce  <= 1'b1;
            ram.ram_wre <= 1'b1;
            ram.ram_ad  <= r_wptr;
            ram.ram_din <= i_adc_data;
            r_wptr      <= w_wptr_nxt;
            r_rem       <= r_rem - ONE_A;
            if (r_rem == ONE_A) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (i_rd_en && (i_rd_addr < DEPTH_A)) begin
            ram.ram_ce  <= 1'b1;
            ram.ram_ad  <= w_rd_phys;
            r_rd_vld[0] <= 1'b1;
          end
          if (i_arm) begin
            r_state <= ST_ARMED;
            r_wptr  <= '0;
            r_fill  <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule
